glyph_reader: RTL and testbench

GLYPH_READER -- requirements
Module: glyph_reader

---
 rtl/glyph_pkg.sv | 26 ++
 rtl/glyph_addr_counter.sv | 48 ++++
 rtl/glyph_reader.sv | 131 +++++++++++++
 tb/tb_glyph_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared geometry and FSM encoding for the glyph reader and glyph writer.
package glyph_pkg;

    localparam int CELL_W     = 8;
    localparam int CELL_H     = 16;
    localparam int GLYPH_BITS = 128;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    typedef logic [9:0] px_x_t;
    typedef logic [8:0] px_y_t;
    typedef logic [6:0] glyph_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } glyph_state_t;

    // Cell index 0 is the top-left pixel and lands in the glyph MSB.
    function automatic glyph_idx_t glyph_bit_pos(input glyph_idx_t idx);
        return glyph_idx_t'(GLYPH_BITS - 1) - idx;
    endfunction

endpackage

// File: rtl/glyph_addr_counter.sv
// Cell index counter plus pixel address generation and screen-bounds flag.
module glyph_addr_counter
    import glyph_pkg::*;
#(
    parameter int         SCREEN_W = 640,
    parameter int         SCREEN_H = 480,
    parameter glyph_idx_t LAST_IDX = glyph_idx_t'(GLYPH_BITS - 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [9:0] base_x,
    input  logic [8:0] base_y,
    output logic [6:0] idx,
    output logic       last,
    output logic [9:0] addr_x,
    output logic [8:0] addr_y,
    output logic       in_range
);

    logic [10:0] sum_x;
    logic [9:0]  sum_y;

    // The index freezes on the last pixel so the address outputs hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (enable) begin
            idx <= idx + 7'd1;
        end
    end

    // A carry out of either sum means the cell wrapped off the addressable range.
    always_comb begin
        sum_x    = {1'b0, base_x} + {8'd0, idx[2:0]};
        sum_y    = {1'b0, base_y} + {6'd0, idx[6:3]};
        addr_x   = px_x_t'(sum_x[9:0]);
        addr_y   = px_y_t'(sum_y[8:0]);
        last     = (idx == LAST_IDX);
        in_range = !sum_x[10] && !sum_y[9]
                   && ({22'd0, addr_x} < SCREEN_W[31:0])
                   && ({23'd0, addr_y} < SCREEN_H[31:0]);
    end

endmodule

// File: rtl/glyph_reader.sv
// Reads one character cell from the framebuffer and packs it into a 128-bit glyph.
module glyph_reader
    import glyph_pkg::*;
#(
    parameter int CELL_W   = 8,
    parameter int CELL_H   = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [9:0]            cell_x,
    input  logic [8:0]            cell_y,
    output logic [9:0]            mem_x,
    output logic [8:0]            mem_y,
    output logic                  mem_rd,
    input  logic [2:0]            mem_colour,
    output logic                  busy,
    output logic                  done,
    output logic [GLYPH_BITS-1:0] glyph
);

    localparam glyph_idx_t LAST_IDX = glyph_idx_t'(CELL_W * CELL_H - 1);

    glyph_state_t state, next_state;

    px_x_t      base_x;
    px_y_t      base_y;
    glyph_idx_t idx;
    logic       last;
    logic       in_range;
    logic       accept;
    logic       issuing;

    logic       pipe_valid;
    logic       pipe_hit;
    glyph_idx_t pipe_idx;

    assign accept  = (state == ST_IDLE) && start;
    assign issuing = (state == ST_ISSUE);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy   = 1'b1;
                mem_rd = in_range;
                if (last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            base_x <= '0;
            base_y <= '0;
        end else if (accept) begin
            base_x <= cell_x;
            base_y <= cell_y;
        end
    end

    glyph_addr_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .LAST_IDX (LAST_IDX)
    ) u_addr (
        .clk      (clk),
        .rst      (reset_n),
        .clear    (accept),
        .enable   (issuing && !last),
        .base_x   (base_x),
        .base_y   (base_y),
        .idx      (idx),
        .last     (last),
        .addr_x   (mem_x),
        .addr_y   (mem_y),
        .in_range (in_range)
    );

    // Read data arrives a cycle after the strobe, so the index and whether a read
    // was actually issued travel alongside it; suppressed reads capture a zero.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            pipe_valid <= 1'b0;
            pipe_hit   <= 1'b0;
            pipe_idx   <= '0;
        end else begin
            pipe_valid <= issuing;
            pipe_hit   <= mem_rd;
            pipe_idx   <= idx;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            glyph <= '0;
        end else if (pipe_valid) begin
            glyph[glyph_bit_pos(pipe_idx)] <= pipe_hit && (mem_colour != 3'b000);
        end
    end

endmodule

// File: tb/tb_glyph_reader.sv
// Self-checking bench for glyph_reader against a pixel-level framebuffer model.
module tb_glyph_reader;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    localparam logic [7:0] FONT_A [16] = '{
        8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
        8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
    };
    localparam logic [127:0] GLYPH_A = {
        8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
        8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
    };

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [9:0]   cell_x;
    logic [8:0]   cell_y;
    logic [9:0]   mem_x;
    logic [8:0]   mem_y;
    logic         mem_rd;
    logic [2:0]   mem_colour;
    logic         busy;
    logic         done;
    logic [127:0] glyph;

    int total = 0;
    int bad   = 0;
    int mem_mode = 0;
    int seed = 0;

    glyph_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .mem_x      (mem_x),
        .mem_y      (mem_y),
        .mem_rd     (mem_rd),
        .mem_colour (mem_colour),
        .busy       (busy),
        .done       (done),
        .glyph      (glyph)
    );

    always #5 clk = ~clk;

    // Framebuffer contents: 0 parity, 1 blank, 2 all 3'b001, 3 hashed, 4 plotted 'A'.
    function automatic logic [2:0] pixel(input int x, input int y);
        logic [7:0] row;
        int h;
        case (mem_mode)
            0: return ((x + y) % 2 == 1) ? 3'b111 : 3'b000;
            1: return 3'b000;
            2: return 3'b001;
            3: begin
                h = (x * 37 + y * 101 + seed) % 11;
                return (h < 5) ? 3'(h + 1) : 3'b000;
            end
            default: begin
                if (x >= 100 && x < 108 && y >= 200 && y < 216) begin
                    row = FONT_A[y - 200];
                    return row[7 - (x - 100)] ? 3'b111 : 3'b000;
                end
                return 3'b000;
            end
        endcase
    endfunction

    function automatic logic [127:0] ref_glyph(input int cx, input int cy);
        logic [127:0] g;
        int x, y;
        g = '0;
        for (int r = 0; r < 16; r++) begin
            for (int col = 0; col < 8; col++) begin
                x = cx + col;
                y = cy + r;
                if (x < SCR_W && y < SCR_H && pixel(x, y) != 3'b000)
                    g[127 - (r * 8 + col)] = 1'b1;
            end
        end
        return g;
    endfunction

    // Unread cycles return garbage so a capture of a suppressed read shows up.
    always @(posedge clk)
        mem_colour <= mem_rd ? pixel(int'(mem_x), int'(mem_y)) : 3'($urandom);

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Called at a negedge; starts one capture and observes it until a few cycles past done.
    task automatic run_capture(input int cx, input int cy, input int p1, input int p2,
                               output int lat, output logic [127:0] g, output int addr_bad,
                               output int rd_cnt, output int busy_cnt, output int done_cnt);
        int i, ex, ey;
        logic erd;
        lat = 0; g = '0; addr_bad = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0;
        cell_x = 10'(cx);
        cell_y = 9'(cy);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cell_x = 10'($urandom);
        cell_y = 9'($urandom);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = (n == p1) || (n == p2);
            if (busy === 1'b1) busy_cnt++;
            if (mem_rd === 1'b1) rd_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (lat == 0) begin
                    lat = n;
                    g = glyph;
                end
            end
            if (n <= 128) begin
                i   = n - 1;
                ex  = (cx + i % 8) % 1024;
                ey  = (cy + i / 8) % 512;
                erd = (cx + i % 8 < SCR_W) && (cy + i / 8 < SCR_H);
                if (int'(mem_x) != ex || int'(mem_y) != ey || mem_rd !== erd) addr_bad++;
            end else begin
                if (mem_rd !== 1'b0 || int'(mem_x) != (cx + 7) % 1024
                    || int'(mem_y) != (cy + 15) % 512) addr_bad++;
            end
            if (lat != 0 && n >= lat + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        cell_x  = 10'd5;
        cell_y  = 9'd5;
        repeat (3) @(negedge clk);
        total++; if (mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_rd got=%b want=0", mem_rd); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (mem_x !== 10'd0) begin bad++; $display("[TB] FAIL reset_mem_x got=%0d want=0", mem_x); end
        total++; if (mem_y !== 9'd0) begin bad++; $display("[TB] FAIL reset_mem_y got=%0d want=0", mem_y); end
        total++; if (glyph !== 128'd0) begin bad++; $display("[TB] FAIL reset_glyph got=%h want=0", glyph); end
        reset_n = 1'b0;
    endtask

    task automatic test_checkerboard();
        int lat, ab, rd, bz, dn;
        logic [127:0] g;
        mem_mode = 0;
        run_capture(16, 32, -1, -1, lat, g, ab, rd, bz, dn);
        total++; if (lat != 130) begin bad++; $display("[TB] FAIL chk_latency got=%0d want=130", lat); end
        total++; if (rd != 128) begin bad++; $display("[TB] FAIL chk_reads got=%0d want=128", rd); end
        total++; if (ab != 0) begin bad++; $display("[TB] FAIL chk_addr got=%0d errors want=0", ab); end
        total++; if (dn != 1) begin bad++; $display("[TB] FAIL chk_done_count got=%0d want=1", dn); end
        total++; if (bz != 129) begin bad++; $display("[TB] FAIL chk_busy_cycles got=%0d want=129", bz); end
        total++; if (g !== {8{16'h55AA}}) begin bad++; $display("[TB] FAIL chk_glyph got=%h want=%h", g, {8{16'h55AA}}); end
        total++; if (glyph !== ref_glyph(16, 32)) begin bad++; $display("[TB] FAIL chk_glyph_hold got=%h want=%h", glyph, ref_glyph(16, 32)); end
    endtask

    task automatic test_all_zero();
        int lat, ab, rd, bz, dn;
        logic [127:0] g;
        mem_mode = 1;
        run_capture(0, 0, -1, -1, lat, g, ab, rd, bz, dn);
        total++; if (g !== 128'd0) begin bad++; $display("[TB] FAIL zero_glyph got=%h want=0", g); end
        total++; if (dn != 1) begin bad++; $display("[TB] FAIL zero_done_count got=%0d want=1", dn); end
        total++; if (bz != 129) begin bad++; $display("[TB] FAIL zero_busy_cycles got=%0d want=129", bz); end
        total++; if (rd != 128 || ab != 0) begin bad++; $display("[TB] FAIL zero_reads got=%0d/%0d want=128/0", rd, ab); end
    endtask

    task automatic test_screen_edge();
        int lat, ab, rd, bz, dn;
        logic [127:0] g;
        logic [127:0] want;
        want = {{4{8'hF0}}, 96'd0};
        mem_mode = 2;
        run_capture(636, 476, -1, -1, lat, g, ab, rd, bz, dn);
        total++; if (rd != 16) begin bad++; $display("[TB] FAIL edge_reads got=%0d want=16", rd); end
        total++; if (ab != 0) begin bad++; $display("[TB] FAIL edge_addr got=%0d errors want=0", ab); end
        total++; if (g !== want) begin bad++; $display("[TB] FAIL edge_glyph got=%h want=%h", g, want); end
        total++; if (g !== ref_glyph(636, 476)) begin bad++; $display("[TB] FAIL edge_glyph_model got=%h want=%h", g, ref_glyph(636, 476)); end
    endtask

    task automatic test_restart_ignored();
        int lat, ab, rd, bz, dn, late_busy;
        logic [127:0] g;
        mem_mode = 0;
        run_capture(100, 50, 5, 128, lat, g, ab, rd, bz, dn);
        late_busy = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) late_busy++;
        end
        total++; if (dn != 1) begin bad++; $display("[TB] FAIL restart_done_count got=%0d want=1", dn); end
        total++; if (lat != 130) begin bad++; $display("[TB] FAIL restart_latency got=%0d want=130", lat); end
        total++; if (g !== ref_glyph(100, 50)) begin bad++; $display("[TB] FAIL restart_glyph got=%h want=%h", g, ref_glyph(100, 50)); end
        total++; if (late_busy != 0) begin bad++; $display("[TB] FAIL restart_queued got=%0d active cycles want=0", late_busy); end
    endtask

    task automatic test_reset_mid();
        int lat, ab, rd, bz, dn, stray;
        logic [127:0] g;
        mem_mode = 0;
        cell_x = 10'd16;
        cell_y = 9'd32;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (61) @(negedge clk);
        total++; if (busy !== 1'b1 || mem_rd !== 1'b1) begin bad++; $display("[TB] FAIL mid_active got=%b%b want=11", busy, mem_rd); end
        reset_n = 1'b1;
        #1;
        total++; if (mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL mid_mem_rd got=%b want=0", mem_rd); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
        total++; if (glyph !== 128'd0) begin bad++; $display("[TB] FAIL mid_glyph got=%h want=0", glyph); end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        stray = 0;
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || glyph !== 128'd0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("[TB] FAIL mid_no_done got=%0d stray cycles want=0", stray); end
        mem_mode = 3;
        seed = 17;
        run_capture(300, 200, -1, -1, lat, g, ab, rd, bz, dn);
        total++; if (lat != 130 || g !== ref_glyph(300, 200)) begin bad++; $display("[TB] FAIL mid_recover got=%0d/%h want=130/%h", lat, g, ref_glyph(300, 200)); end
    endtask

    task automatic test_random_cells();
        int lat, ab, rd, bz, dn, cx, cy;
        logic [127:0] g;
        mem_mode = 3;
        for (int k = 0; k < 6; k++) begin
            seed = int'($urandom_range(0, 1000));
            if (k % 2 == 0) begin
                cx = int'($urandom_range(0, 1023));
                cy = int'($urandom_range(0, 511));
            end else begin
                cx = int'($urandom_range(600, 1023));
                cy = int'($urandom_range(440, 511));
            end
            run_capture(cx, cy, -1, -1, lat, g, ab, rd, bz, dn);
            total++; if (g !== ref_glyph(cx, cy)) begin bad++; $display("[TB] FAIL rand_glyph cell=(%0d,%0d) got=%h want=%h", cx, cy, g, ref_glyph(cx, cy)); end
            total++; if (ab != 0) begin bad++; $display("[TB] FAIL rand_addr cell=(%0d,%0d) got=%0d errors want=0", cx, cy, ab); end
            total++; if (lat != 130 || dn != 1) begin bad++; $display("[TB] FAIL rand_done cell=(%0d,%0d) got=%0d/%0d want=130/1", cx, cy, lat, dn); end
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, idle_busy;
        logic [127:0] g1, g2;
        mem_mode = 0;
        d1 = 0; d2 = 0; g1 = '0; g2 = '0;
        cell_x = 10'd40;
        cell_y = 9'd40;
        start  = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = n; g1 = glyph;
                end else begin
                    d2 = n; g2 = glyph;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        idle_busy = 0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        total++; if (d1 != 130) begin bad++; $display("[TB] FAIL b2b_first_done got=%0d want=130", d1); end
        total++; if (d2 - d1 != 131) begin bad++; $display("[TB] FAIL b2b_gap got=%0d want=131", d2 - d1); end
        total++; if (g1 !== ref_glyph(40, 40) || g2 !== ref_glyph(40, 40)) begin bad++; $display("[TB] FAIL b2b_glyph got=%h want=%h", g2, ref_glyph(40, 40)); end
        total++; if (idle_busy != 0) begin bad++; $display("[TB] FAIL b2b_stop got=%0d busy cycles want=0", idle_busy); end
    endtask

    task automatic test_round_trip();
        int lat, ab, rd, bz, dn;
        logic [127:0] g;
        mem_mode = 4;
        run_capture(100, 200, -1, -1, lat, g, ab, rd, bz, dn);
        total++; if (g !== GLYPH_A) begin bad++; $display("[TB] FAIL roundtrip_glyph got=%h want=%h", g, GLYPH_A); end
        total++; if (lat != 130) begin bad++; $display("[TB] FAIL roundtrip_latency got=%0d want=130", lat); end
    endtask

    initial begin
        $display("[TB] glyph_reader bench starting");
        test_reset();
        test_checkerboard();
        test_all_zero();
        test_screen_edge();
        test_restart_ignored();
        test_reset_mid();
        test_random_cells();
        test_back_to_back();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
